// File: rtl/id_hazard_branch.sv
// id_hazard_branch: IF/ID register, control-flow resolution in ID, load-use and
// branch-operand hazard detection, and saturating stall/flush counters.
module id_hazard_branch #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction_if,
    input  logic [31:0]      PC,
    input  logic [31:0]      RsData,
    input  logic [31:0]      RtData,
    input  logic             MemRead_ex,
    input  logic             RegWrite_ex,
    input  logic [4:0]       WriteReg_ex,
    input  logic             MemRead_mem,
    input  logic [4:0]       WriteReg_mem,
    output logic             Branch,
    output logic             Jump,
    output logic [31:0]      JumpAddr,
    output logic             IFWrite,
    output logic [31:0]      Instruction_id,
    output logic [31:0]      NextPC_id,
    output logic             Bubble_id,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);
    logic [31:0]      r_instr, r_npc;
    logic             r_valid;
    logic [CNT_W-1:0] r_scnt, r_fcnt;
    logic [5:0]       w_op;
    logic [4:0]       w_rs, w_rt;
    logic [15:0]      w_imm;
    logic             w_beq, w_bne, w_jmp, w_uses_rt;
    logic             w_ex_hit, w_mem_hit, w_load_use, w_br_haz, w_stall, w_redir;

    assign w_op      = r_instr[31:26];
    assign w_rs      = r_instr[25:21];
    assign w_rt      = r_instr[20:16];
    assign w_imm     = r_instr[15:0];
    assign w_beq     = w_op == 6'b000100;
    assign w_bne     = w_op == 6'b000101;
    assign w_jmp     = w_op == 6'b000010 || w_op == 6'b000011;
    assign w_uses_rt = w_op == 6'b000000 || w_beq || w_bne || w_op[5:3] == 3'b101;

    assign w_ex_hit  = WriteReg_ex != 5'd0 && (WriteReg_ex == w_rs || WriteReg_ex == w_rt);
    assign w_mem_hit = WriteReg_mem != 5'd0 && (WriteReg_mem == w_rs || WriteReg_mem == w_rt);
    // Jumps carry target bits in the rs/rt fields, so they are excluded from hazards.
    assign w_load_use = r_valid && !w_jmp && MemRead_ex && WriteReg_ex != 5'd0 &&
                        (WriteReg_ex == w_rs || (w_uses_rt && WriteReg_ex == w_rt));
    assign w_br_haz   = r_valid && (w_beq || w_bne) &&
                        ((RegWrite_ex && w_ex_hit) || (MemRead_mem && w_mem_hit));
    assign w_stall    = w_load_use || w_br_haz;

    assign Branch   = r_valid && !w_stall &&
                      ((w_beq && RsData == RtData) || (w_bne && RsData != RtData));
    assign Jump     = r_valid && w_jmp;
    assign w_redir  = Branch || Jump;
    assign JumpAddr = Jump ? {r_npc[31:28], r_instr[25:0], 2'b00}
                           : r_npc + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign IFWrite        = !w_stall;
    assign Bubble_id      = w_stall;
    assign Instruction_id = r_instr;
    assign NextPC_id      = r_npc;
    assign StallCnt       = r_scnt;
    assign FlushCnt       = r_fcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= NOP_WORD;
            r_npc   <= '0;
            r_valid <= 1'b0;
            r_scnt  <= '0;
            r_fcnt  <= '0;
        end else begin
            if (!w_stall) begin
                r_instr <= w_redir ? NOP_WORD : Instruction_if;
                r_npc   <= w_redir ? 32'd0 : PC + 32'd4;
                r_valid <= !w_redir;
            end
            if (w_stall && r_scnt != '1) r_scnt <= r_scnt + CNT_W'(1);
            if (w_redir && r_fcnt != '1) r_fcnt <= r_fcnt + CNT_W'(1);
        end
    end
endmodule
